dlfloat_mac_seq: RTL and testbench

Sequencer for the DLFloat16 MAC datapath. It accepts an 8-bit operand byte stream with a valid/ready handshake and assembles 16-bit a/b operand pairs. For each dot product it clears the accumulator, issues a programmed number of multiply-accumulate terms, waits out the MAC pipeline, then returns the 16-bit result as two bytes over a valid/ready output. It sits between the chip's byte-wide I/O and the MAC core, replacing free-running two-phase load/unload.

---
 rtl/dlfloat_mac_seq_if.sv | 22 ++
 rtl/dlfloat_mac_seq.sv | 199 +++++++++++++++++++
 tb/tb_dlfloat_mac_seq.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dlfloat_mac_seq_if.sv
// ---------------------------------------------------------------------------
// dlfloat_mac_seq_if
//   Byte-wide valid/ready stream used for both the operand input and the
//   result output of the DLFloat16 MAC sequencer.
//
//   Handshake: a byte moves on every rising clock edge where valid and ready
//   are both high. The master holds data and valid stable until that edge;
//   ready may change freely and never waits on valid.
//
//   Signals:
//     data  [7:0]  payload byte (master -> slave)
//     valid        data is valid (master -> slave)
//     ready        slave accepts data (slave -> master)
// ---------------------------------------------------------------------------
interface dlfloat_mac_seq_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dlfloat_mac_seq.sv
// ---------------------------------------------------------------------------
// dlfloat_mac_seq
//   Sequencer for the DLFloat16 MAC datapath. Assembles 16-bit a/b operand
//   pairs from a byte stream, clears the MAC accumulator, issues cfg_len
//   multiply-accumulate terms, waits out the MAC pipeline and returns the
//   16-bit result as two bytes (low byte first).
//
//   Optional feature macro: DLF_SEQ_NAN_ABORT_EN
//     When defined, a term whose operand is 16'hFFFF is not issued, a sticky
//     flag is set, and the returned result is forced to 16'hFFFF. Remaining
//     terms are still consumed so the byte stream stays aligned.
//
//   Parameters:
//     LEN_W    width of cfg_len
//     MAC_LAT  cycles from mac_issue until mac_acc reflects the term (>= 1)
//
//   Ports:
//     clk, rst      clock; synchronous active-high reset
//     start         begin a dot product (honoured only in IDLE)
//     cfg_len       number of terms, sampled on an accepted start
//     busy          high in every state except IDLE
//     done          one-cycle pulse when the high result byte is accepted
//     in_if         operand byte stream (slave); ready only in LOAD
//     mac_a, mac_b  registered operands to the MAC
//     mac_issue     one-cycle pulse: MAC consumes mac_a/mac_b
//     mac_clr       one-cycle pulse: MAC accumulator cleared
//     mac_acc       MAC accumulator value
//     out_if        result byte stream (master); data is 0x00 when not valid
//     dbg_state_o   current FSM state
// ---------------------------------------------------------------------------
module dlfloat_mac_seq #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic                  busy,
  output logic                  done,
  dlfloat_mac_seq_if.slave      in_if,
  output logic [15:0]           mac_a,
  output logic [15:0]           mac_b,
  output logic                  mac_issue,
  output logic                  mac_clr,
  input  logic [15:0]           mac_acc,
  dlfloat_mac_seq_if.master     out_if,
  output logic [2:0]            dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_OUT_LO = 3'd5;
  localparam logic [2:0] S_OUT_HI = 3'd6;

  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAC_LAT - 1);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  // One bit wider than cfg_len so an all-ones length still terminates.
  logic [LEN_W:0]   term_q, term_d;
  logic [LEN_W:0]   term_inc;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic [15:0]      result_q, result_d;
  logic             issue_ok;

`ifdef DLF_SEQ_NAN_ABORT_EN
  logic nan_q, nan_d;
  logic nan_hit;
  assign nan_hit  = (a_q == 16'hFFFF) || (b_q == 16'hFFFF);
  assign issue_ok = !nan_hit;
`else
  assign issue_ok = 1'b1;
`endif

  assign term_inc = term_q + {{LEN_W{1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    term_d     = term_q;
    byte_idx_d = byte_idx_q;
    lat_d      = lat_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
`ifdef DLF_SEQ_NAN_ABORT_EN
    nan_d      = nan_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = cfg_len;
          term_d     = '0;
          byte_idx_d = 2'd0;
          state_d    = S_CLR;
        end
      end
      S_CLR: begin
        lat_d = '0;
`ifdef DLF_SEQ_NAN_ABORT_EN
        nan_d = 1'b0;
`endif
        state_d = (len_q == '0) ? S_DRAIN : S_LOAD;
      end
      S_LOAD: begin
        if (in_if.valid) begin
          case (byte_idx_q)
            2'd0:    a_d[7:0]  = in_if.data;
            2'd1:    a_d[15:8] = in_if.data;
            2'd2:    b_d[7:0]  = in_if.data;
            default: b_d[15:8] = in_if.data;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        term_d = term_inc;
`ifdef DLF_SEQ_NAN_ABORT_EN
        if (nan_hit) nan_d = 1'b1;
`endif
        if (term_inc == {1'b0, len_q}) begin
          state_d = S_DRAIN;
          lat_d   = '0;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (lat_q == LAT_LAST) begin
          result_d = (len_q == '0) ? 16'h0000 : mac_acc;
`ifdef DLF_SEQ_NAN_ABORT_EN
          if (nan_q) result_d = 16'hFFFF;
`endif
          state_d = S_OUT_LO;
        end else begin
          lat_d = lat_q + {{(LAT_W-1){1'b0}}, 1'b1};
        end
      end
      S_OUT_LO: begin
        if (out_if.ready) state_d = S_OUT_HI;
      end
      S_OUT_HI: begin
        if (out_if.ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      term_q     <= '0;
      byte_idx_q <= 2'd0;
      lat_q      <= '0;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      result_q   <= 16'h0000;
`ifdef DLF_SEQ_NAN_ABORT_EN
      nan_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      term_q     <= term_d;
      byte_idx_q <= byte_idx_d;
      lat_q      <= lat_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
`ifdef DLF_SEQ_NAN_ABORT_EN
      nan_q      <= nan_d;
`endif
    end
  end

  // All control outputs are decoded from the registered state.
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_OUT_HI) && out_if.ready;
  assign in_if.ready  = (state_q == S_LOAD);
  assign mac_issue    = (state_q == S_ISSUE) && issue_ok;
  assign mac_clr      = (state_q == S_CLR);
  assign mac_a        = a_q;
  assign mac_b        = b_q;
  assign out_if.valid = (state_q == S_OUT_LO) || (state_q == S_OUT_HI);
  assign out_if.data  = (state_q == S_OUT_LO) ? result_q[7:0]  :
                        (state_q == S_OUT_HI) ? result_q[15:8] : 8'h00;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_dlfloat_mac_seq
//   Directed bench for dlfloat_mac_seq. A stand-in MAC accumulates a+b
//   (16-bit wrap) with MAC_LAT cycles of visibility delay, so the expected
//   results in the vector table are simple hand sums.
// ---------------------------------------------------------------------------
module tb_dlfloat_mac_seq;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             busy, done, mac_issue, mac_clr;
  logic [15:0]      mac_a, mac_b, mac_acc;
  logic [2:0]       dbg_state;

  dlfloat_mac_seq_if in_if ();
  dlfloat_mac_seq_if out_if ();

  initial begin
    in_if.data   = 8'h00;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
  end

  dlfloat_mac_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .done       (done),
    .in_if      (in_if),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_issue  (mac_issue),
    .mac_clr    (mac_clr),
    .mac_acc    (mac_acc),
    .out_if     (out_if),
    .dbg_state_o(dbg_state)
  );

  // ---------------- stand-in MAC ----------------
  logic [15:0] arch_q;
  logic [15:0] arch_n;
  logic [15:0] hist_q [MAC_LAT];

  always_comb begin
    arch_n = arch_q;
    if (mac_clr) arch_n = 16'h0000;
    else if (mac_issue) arch_n = arch_q + mac_a + mac_b;
  end

  always @(posedge clk) begin
    if (rst) begin
      arch_q <= 16'h0000;
      for (int k = 0; k < MAC_LAT; k++) hist_q[k] <= 16'h0000;
    end else begin
      arch_q    <= arch_n;
      hist_q[0] <= arch_n;
      for (int k = 1; k < MAC_LAT; k++) hist_q[k] <= hist_q[k-1];
    end
  end
  assign mac_acc = hist_q[MAC_LAT-1];

  // ---------------- monitors ----------------
  int issue_cnt = 0, clr_cnt = 0, done_cnt = 0, inrdy_cnt = 0, proto_err = 0;
  int ov_rise_cyc = -1;
  logic ov_prev = 1'b0;

  always @(negedge clk) begin
    if (mac_issue) issue_cnt <= issue_cnt + 1;
    if (mac_clr) clr_cnt <= clr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (in_if.ready) inrdy_cnt <= inrdy_cnt + 1;
    // in_ready must never overlap any non-LOAD activity.
    if (in_if.ready && (!busy || mac_issue || mac_clr || out_if.valid))
      proto_err <= proto_err + 1;
    if (!out_if.valid && out_if.data != 8'h00) proto_err <= proto_err + 1;
    if (out_if.valid && !ov_prev) ov_rise_cyc <= cyc;
    ov_prev <= out_if.valid;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All driving and checking happens 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  int last_acc = 0;
  int start_cyc = 0;

  task automatic pulse_start(input int len);
    cfg_len = LEN_W'(len);
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    cfg_len = 8'hA5;  // changes while busy must have no effect
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    in_if.valid = 1'b0;
    repeat (gap) step();
    in_if.data  = b;
    in_if.valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (in_if.ready) begin
        last_acc = cyc;
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    in_if.valid = 1'b0;
    if (!ok) chk("in_accept_timeout", 32'd0, 32'd1);
  endtask

  // Waits for out_valid, holds out_ready low for 'hold' cycles, then takes
  // both bytes. Returns the bytes, done seen with the high byte, and busy
  // in the following cycle.
  task automatic collect_out(input int hold, output logic [7:0] lo, output logic [7:0] hi,
                             output logic d, output logic b);
    bit ok;
    ok = 1'b0;
    lo = 8'h00; hi = 8'h00; d = 1'b0; b = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (out_if.valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (hold) step();
    out_if.ready = 1'b1;
    lo = out_if.data;
    step();
    hi = out_if.data;
    d  = done;
    step();
    out_if.ready = 1'b0;
    b = busy;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          len;
    logic [95:0] bytes;   // byte i at bits [8*i +: 8]; each term is {b, a}
    int          gap;     // idle cycles before each byte
    logic [15:0] exp_res;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t tbl[4];

  task automatic run_vec(input vec_t v, input string tag);
    int b_issue, b_clr, b_done, b_rdy;
    logic [7:0] lo, hi;
    logic d, bz;
    b_issue = issue_cnt; b_clr = clr_cnt; b_done = done_cnt; b_rdy = inrdy_cnt;
    exp_q.push_back(v.exp_res);
    pulse_start(v.len);
    chk({tag, "_mac_clr"}, 32'(mac_clr), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_in_ready_after_clr"}, 32'(in_if.ready), (v.len == 0) ? 32'd0 : 32'd1);
    for (int i = 0; i < 4 * v.len; i++) send_byte(v.bytes[8*i +: 8], v.gap);
    collect_out(0, lo, hi, d, bz);
    begin
      logic [15:0] e;
      e = exp_q.pop_front();
      chk({tag, "_out_lo"}, 32'(lo), 32'(e[7:0]));
      chk({tag, "_out_hi"}, 32'(hi), 32'(e[15:8]));
    end
    chk({tag, "_done_with_hi"}, 32'(d), 32'd1);
    chk({tag, "_busy_after_done"}, 32'(bz), 32'd0);
    chk({tag, "_issue_count"}, 32'(issue_cnt - b_issue), 32'(v.len));
    chk({tag, "_clr_count"}, 32'(clr_cnt - b_clr), 32'd1);
    chk({tag, "_done_count"}, 32'(done_cnt - b_done), 32'd1);
    if (v.len == 0) begin
      chk({tag, "_no_in_ready"}, 32'(inrdy_cnt - b_rdy), 32'd0);
      chk({tag, "_out_latency"}, 32'(ov_rise_cyc), 32'(start_cyc + 2 + MAC_LAT));
    end else begin
      chk({tag, "_out_latency"}, 32'(ov_rise_cyc), 32'(last_acc + 2 + MAC_LAT));
      chk({tag, "_mac_a"}, 32'(mac_a), 32'(v.exp_a));
      chk({tag, "_mac_b"}, 32'(mac_b), 32'(v.exp_b));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [7:0] lo, hi;
    logic d, bz;
    int b_clr, b_done, b_issue, bad;

    tbl[0] = '{len: 1, bytes: 96'h3C00_3C00, gap: 0,
               exp_res: 16'h7800, exp_a: 16'h3C00, exp_b: 16'h3C00};
    tbl[1] = '{len: 3, bytes: 96'h2000_1000_0003_0002_0101_1234, gap: 1,
               exp_res: 16'h433A, exp_a: 16'h1000, exp_b: 16'h2000};
    tbl[2] = '{len: 0, bytes: 96'h0, gap: 0,
               exp_res: 16'h0000, exp_a: 16'h0000, exp_b: 16'h0000};
    tbl[3] = '{len: 2, bytes: 96'h9000_8000_0002_00FF, gap: 0,
               exp_res: 16'h1101, exp_a: 16'h8000, exp_b: 16'h9000};

    // reset state
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_if.ready), 32'd0);
    chk("rst_mac_issue", 32'(mac_issue), 32'd0);
    chk("rst_mac_clr", 32'(mac_clr), 32'd0);
    chk("rst_out_valid", 32'(out_if.valid), 32'd0);
    chk("rst_out_byte", 32'(out_if.data), 32'd0);
    chk("rst_mac_a", 32'(mac_a), 32'd0);
    chk("rst_mac_b", 32'(mac_b), 32'd0);
    step();

    // table vectors, back-to-back
    for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // output stall: out_ready low 10 cycles, start ignored meanwhile
    b_clr = clr_cnt; b_done = done_cnt;
    pulse_start(1);
    step();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    bad = 0;
    for (int n = 0; n < 40 && !out_if.valid; n++) step();
    for (int n = 0; n < 10; n++) begin
      if (n == 4) begin start = 1'b1; cfg_len = 8'd5; end
      if (n == 5) start = 1'b0;
      if (out_if.data != 8'h03 || !out_if.valid || done) bad++;
      step();
    end
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_no_clr", 32'(clr_cnt - b_clr), 32'd1);
    collect_out(0, lo, hi, d, bz);
    chk("stall_out_lo", 32'(lo), 32'h03);
    chk("stall_out_hi", 32'(hi), 32'h00);
    chk("stall_done", 32'(done_cnt - b_done), 32'd1);
    step(); step();
    chk("stall_start_not_queued", 32'(clr_cnt - b_clr), 32'd1);
    chk("stall_idle", 32'(busy), 32'd0);

    // reset mid-load after 2 of 4 bytes
    b_done = done_cnt; b_issue = issue_cnt;
    pulse_start(1);
    step();
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_if.ready), 32'd0);
    chk("midrst_mac_a", 32'(mac_a), 32'd0);
    chk("midrst_out_valid", 32'(out_if.valid), 32'd0);
    chk("midrst_no_done", 32'(done_cnt - b_done), 32'd0);
    chk("midrst_no_issue", 32'(issue_cnt - b_issue), 32'd0);
    step();
    run_vec(tbl[0], "post_rst");

`ifdef DLF_SEQ_NAN_ABORT_EN
    // NaN abort: first term a=0xFFFF, two terms, only the second issues
    b_issue = issue_cnt;
    pulse_start(2);
    step();
    send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    collect_out(0, lo, hi, d, bz);
    chk("nan_issue_count", 32'(issue_cnt - b_issue), 32'd1);
    chk("nan_out_lo", 32'(lo), 32'hFF);
    chk("nan_out_hi", 32'(hi), 32'hFF);
    chk("nan_done", 32'(d), 32'd1);
`endif

    step();
    chk("protocol_violations", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
